pixel_unpack_rd: RTL and testbench
==================================

PIXEL_UNPACK_RD -- requirements
Module: pixel_unpack_rd

Interface
REQ-001 The block SHALL have parameter CH_W, default 8, meaning bits per colour channel.
REQ-002 The block SHALL have parameter CH_N, default 3, meaning channels per pixel word.
REQ-003 The block SHALL have parameter LINE_PIX, default 640, meaning pixels per line; legal range is 2 or more.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, as ports clk and rst_n.
REQ-005 The block SHALL have port clk, input, width 1, the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst_n, input, width 1, the asynchronous active-low reset.
REQ-007 The block SHALL have port fifo_data_rd, input, width CH_N*CH_W, the read word from the upstream FIFO.
REQ-008 The block SHALL have port fifo_empty, input, width 1, the upstream FIFO empty flag.
REQ-009 The block SHALL have port fifo_rd_en, output, width 1, the upstream FIFO pop strobe.
REQ-010 The block SHALL have port pix_data, output, width CH_N*CH_W, the unpacked pixel; channel 0 occupies the MSB slice.
REQ-011 The block SHALL have port pix_valid, output, width 1, meaning pix_data is valid.
REQ-012 The block SHALL have port pix_ready, input, width 1, the downstream accept signal.
REQ-013 The block SHALL have port pix_eol, output, width 1, the last-pixel-of-line marker, qualified by pix_valid.
REQ-014 The block SHALL have port pix_cnt, output, width clog2(LINE_PIX), the index of the presented pixel within its line.

Function
REQ-015 The block SHALL assume a 1-cycle FIFO read latency: a word is captured the cycle after fifo_rd_en=1.
REQ-016 The block SHALL buffer pixels in 2 entries: a head register driving pix_data and a skid register.
REQ-017 The block SHALL define occ (0..2) as filled entries and infl (0..1) as a read issued in the previous cycle.
REQ-018 The block SHALL drive fifo_rd_en = !fifo_empty && (occ + infl - (pix_valid && pix_ready)) < 2; this path is combinational and sustains 1 pixel/cycle.
REQ-019 The block SHALL write a captured word to the head register if the head is empty or is being popped in that cycle, and otherwise to the skid register.
REQ-020 On a pop with the skid register full, the block SHALL move the skid contents to the head in the same cycle, preserving order.
REQ-021 The block SHALL hold pix_valid=1 and pix_data stable until pix_ready=1; there is no drop and no reorder.
REQ-022 The block SHALL count accepted pixels in pix_cnt; pix_cnt SHALL wrap from LINE_PIX-1 to 0 on accept.
REQ-023 The block SHALL drive pix_eol=1 exactly when pix_valid=1 and pix_cnt=LINE_PIX-1.
REQ-024 With fifo_empty=1, the block SHALL not issue reads; if the buffer is also drained, pix_valid=0 and pix_cnt holds.
REQ-025 With pix_ready=0 and both entries full, fifo_rd_en SHALL be 0 and occ+infl SHALL never exceed 2.
REQ-026 When capture and pop occur in the same cycle, occ SHALL remain unchanged.

Reset
REQ-027 On rst_n=0, asynchronously, the block SHALL set pix_valid=0, fifo_rd_en=0, pix_eol=0, pix_cnt=0, pix_data=0, occ=0 and infl=0.
REQ-028 A read in flight at reset assertion SHALL be discarded; after release the first captured word is pixel index 0.
REQ-029 After rst_n rises, the block SHALL issue its first read no earlier than the first clock edge.

Configuration
REQ-030 With PIXEL_UNPACK_SWAP_EN defined, the block SHALL add input chan_swap (1 bit); when chan_swap=1 at capture, it SHALL store channel k of the word as channel CH_N-1-k.
REQ-031 The block SHALL sample chan_swap per word at capture time, so changing it mid-stream affects only later captures.
REQ-032 Without PIXEL_UNPACK_SWAP_EN, the chan_swap port SHALL be absent and the channel order SHALL be fixed and identical to the fifo_data_rd layout.

Verification
REQ-033 Reset release: hold fifo_empty=1 and pix_ready=1 for 10 cycles -> fifo_rd_en=0, pix_valid=0 and pix_cnt=0 throughout.
REQ-034 Streaming: present 24-bit words 0xFF0000, 0x00FF00, 0x0000FF back-to-back with pix_ready=1 -> pix_data emits the same words at 1 per cycle, the first at 2 cycles after the first fifo_rd_en.
REQ-035 Backpressure: 5 words with pix_ready=0 -> exactly 2 reads issued, pix_data holds the first word; on pix_ready=1, all 5 words emerge in order with no gaps beyond the refill.
REQ-036 Line wrap: with LINE_PIX=4, stream 9 pixels -> pix_eol high on pixels 3 and 7, and pix_cnt sequence 0,1,2,3,0,1,2,3,0.
REQ-037 Mid-read reset: assert rst_n=0 in the cycle after fifo_rd_en=1 -> the word is not presented after release, and pix_cnt=0.
REQ-038 Swap, with PIXEL_UNPACK_SWAP_EN defined and chan_swap=1: input 0x112233 -> pix_data=0x332211; with chan_swap=0 -> pix_data=0x112233.

Source files
------------

// File: rtl/pixel_unpack_rd.sv
// Two-entry (head + skid) pixel unpacker that reads a 1-cycle-latency FIFO at up to 1 word/cycle.
// Optional PIXEL_UNPACK_SWAP_EN adds chan_swap to reverse channel order at capture.
module pixel_unpack_rd #(
    parameter int unsigned CH_W     = 8,
    parameter int unsigned CH_N     = 3,
    parameter int unsigned LINE_PIX = 640,
    localparam int unsigned PIX_W   = CH_N * CH_W,
    localparam int unsigned CNT_W   = $clog2(LINE_PIX)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] fifo_data_rd,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
`ifdef PIXEL_UNPACK_SWAP_EN
    input  logic             chan_swap,
`endif
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             pix_eol,
    output logic [CNT_W-1:0] pix_cnt
);

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(LINE_PIX - 1);

    logic [PIX_W-1:0] head_q, skid_q, cap_data;
    logic             head_vld_q, skid_vld_q, infl_q, run_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pop;
    logic [2:0]       pending;

    always_comb begin
        cap_data = fifo_data_rd;
`ifdef PIXEL_UNPACK_SWAP_EN
        if (chan_swap) begin
            for (int k = 0; k < int'(CH_N); k++) begin
                cap_data[k*CH_W +: CH_W] = fifo_data_rd[(int'(CH_N) - 1 - k)*CH_W +: CH_W];
            end
        end
`endif
    end

    assign pop = head_vld_q && pix_ready;

    // Entries held after this edge if we read now; pop implies head full, so no underflow.
    assign pending = {2'b00, head_vld_q} + {2'b00, skid_vld_q} + {2'b00, infl_q} - {2'b00, pop};

    // run_q blocks reads until the first edge after reset release.
    assign fifo_rd_en = run_q && !fifo_empty && (pending < 3'd2);

    assign pix_data  = head_q;
    assign pix_valid = head_vld_q;
    assign pix_cnt   = cnt_q;
    assign pix_eol   = head_vld_q && (cnt_q == LastIdx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            skid_q     <= '0;
            head_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            infl_q     <= 1'b0;
            run_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            run_q  <= 1'b1;
            infl_q <= fifo_rd_en;

            if (pop) begin
                cnt_q <= (cnt_q == LastIdx) ? '0 : cnt_q + 1'b1;
            end

            if (pop) begin
                if (skid_vld_q) begin
                    // Older skid word advances; a new capture lands behind it.
                    head_q     <= skid_q;
                    skid_vld_q <= infl_q;
                    if (infl_q) begin
                        skid_q <= cap_data;
                    end
                end else begin
                    head_vld_q <= infl_q;
                    if (infl_q) begin
                        head_q <= cap_data;
                    end
                end
            end else if (infl_q) begin
                if (!head_vld_q) begin
                    head_q     <= cap_data;
                    head_vld_q <= 1'b1;
                end else begin
                    skid_q     <= cap_data;
                    skid_vld_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_unpack_rd.sv
// Randomised and directed bench for pixel_unpack_rd, checked against an in-order stream model.
module tb_pixel_unpack_rd;

    localparam int CH_W = 8, CH_N = 3, LINE_PIX = 4;
    localparam int W = CH_N * CH_W;
    localparam int CW = $clog2(LINE_PIX);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  fifo_data_rd = '0;
    logic          fifo_empty = 1'b1;
    logic          pix_ready = 1'b0;
    logic          fifo_rd_en, pix_valid, pix_eol;
    logic [W-1:0]  pix_data;
    logic [CW-1:0] pix_cnt;
`ifdef PIXEL_UNPACK_SWAP_EN
    logic          chan_swap = 1'b0;
`endif

    pixel_unpack_rd #(.CH_W(CH_W), .CH_N(CH_N), .LINE_PIX(LINE_PIX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_data_rd (fifo_data_rd),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
`ifdef PIXEL_UNPACK_SWAP_EN
        .chan_swap    (chan_swap),
`endif
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_eol      (pix_eol),
        .pix_cnt      (pix_cnt)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    logic [W-1:0] src[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] out_log[$];
    int           out_cyc[$];
    int           out_cnt[$];
    int           out_eol[$];
    int           rd_issued = 0, accepted = 0, acc_mod = 0, first_rd_cyc = -1;
    logic         rd_s = 1'b0, last_pop = 1'b0, prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [W-1:0] model_word(input logic [W-1:0] w);
        logic [W-1:0] r;
        r = w;
`ifdef PIXEL_UNPACK_SWAP_EN
        if (chan_swap) r = {w[7:0], w[15:8], w[23:16]};
`endif
        return r;
    endfunction

    // Compare process: the output must be the FIFO word sequence, in order, counted modulo a line.
    always @(negedge clk) begin
        cyc++;
        rd_s = fifo_rd_en;
        if (!rst_n) begin
            check("rst_rd_en", 64'(fifo_rd_en), 64'(0));
            check("rst_valid", 64'(pix_valid), 64'(0));
            check("rst_eol", 64'(pix_eol), 64'(0));
            check("rst_cnt", 64'(pix_cnt), 64'(0));
            check("rst_data", 64'(pix_data), 64'(0));
            rd_issued = 0; accepted = 0; acc_mod = 0; first_rd_cyc = -1;
            prev_stall = 1'b0;
            out_log.delete(); out_cyc.delete(); out_cnt.delete(); out_eol.delete();
            exp_q.delete();
            foreach (src[i]) exp_q.push_back(model_word(src[i]));
        end else begin
            if (fifo_rd_en) begin
                check("rd_while_empty", 64'(fifo_empty), 64'(0));
                rd_issued++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            check("cnt", 64'(pix_cnt), 64'(acc_mod));
            check("eol", 64'(pix_eol), 64'(pix_valid && acc_mod == LINE_PIX - 1));
            if (prev_stall) begin
                check("hold_valid", 64'(pix_valid), 64'(1));
                check("hold_data", 64'(pix_data), 64'(prev_data));
            end
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) check("unexpected_pixel", 64'(pix_data), 64'hDEAD);
                else check("data", 64'(pix_data), 64'(exp_q.pop_front()));
                out_log.push_back(pix_data);
                out_cyc.push_back(cyc);
                out_cnt.push_back(int'(pix_cnt));
                out_eol.push_back(int'(pix_eol));
                accepted++;
                acc_mod = (acc_mod + 1) % LINE_PIX;
            end
            check("occupancy", 64'((rd_issued - accepted) <= 2), 64'(1));
            prev_stall = pix_valid && !pix_ready;
            prev_data = pix_data;
        end
    end

    // FIFO model: a read sampled in cycle N delivers its word during cycle N+1.
    task automatic step(input logic rdy);
        @(posedge clk); #1;
        last_pop = 1'b0;
        if (rd_s && src.size() > 0) begin
            fifo_data_rd = src.pop_front();
            last_pop = 1'b1;
        end
        pix_ready = rdy;
        fifo_empty = (src.size() == 0);
    endtask

    task automatic push_word(input logic [W-1:0] w);
        src.push_back(w);
        exp_q.push_back(model_word(w));
        fifo_empty = 1'b0;
    endtask

    task automatic do_reset();
        step(pix_ready);
        rst_n = 1'b0;
        step(1'b0);
        step(1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] words[3];
        int cnt_ref[9];
        words = '{24'hFF0000, 24'h00FF00, 24'h0000FF};
        cnt_ref = '{0, 1, 2, 3, 0, 1, 2, 3, 0};

        // Reset, then idle with an empty FIFO.
        step(1'b0); step(1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            @(negedge clk); #1;
            check("idle_rd_en", 64'(fifo_rd_en), 64'(0));
            check("idle_valid", 64'(pix_valid), 64'(0));
            check("idle_cnt", 64'(pix_cnt), 64'(0));
        end

        // Words waiting at release: no read before the first edge, then 1/cycle at latency 2.
        step(1'b1);
        rst_n = 1'b0;
        foreach (words[i]) push_word(words[i]);
        step(1'b1); step(1'b1);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("no_rd_at_release", 64'(fifo_rd_en), 64'(0));
        for (int i = 0; i < 7; i++) step(1'b1);
        check("stream_n", 64'(out_log.size()), 64'(3));
        if (out_log.size() == 3) begin
            for (int i = 0; i < 3; i++) check("stream_word", 64'(out_log[i]), 64'(words[i]));
            check("stream_latency", 64'(out_cyc[0] - first_rd_cyc), 64'(2));
            check("stream_rate", 64'(out_cyc[2] - out_cyc[0]), 64'(2));
        end

        // Backpressure: only two reads may be issued while stalled.
        do_reset();
        for (int i = 0; i < 5; i++) push_word(24'hA00000 + 24'(i));
        for (int i = 0; i < 10; i++) step(1'b0);
        @(negedge clk); #1;
        check("bp_reads", 64'(rd_issued), 64'(2));
        check("bp_valid", 64'(pix_valid), 64'(1));
        check("bp_head", 64'(pix_data), 64'(24'hA00000));
        for (int i = 0; i < 8; i++) step(1'b1);
        check("bp_n", 64'(out_log.size()), 64'(5));
        if (out_log.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check("bp_word", 64'(out_log[i]), 64'(24'hA00000 + 24'(i)));
                if (i > 0) check("bp_no_gap", 64'(out_cyc[i] - out_cyc[i-1]), 64'(1));
            end
        end

        // Line wrap with LINE_PIX = 4.
        do_reset();
        for (int i = 0; i < 9; i++) push_word(24'h100000 + 24'(i));
        for (int i = 0; i < 14; i++) step(1'b1);
        check("wrap_n", 64'(out_cnt.size()), 64'(9));
        if (out_cnt.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                check("wrap_cnt", 64'(out_cnt[i]), 64'(cnt_ref[i]));
                check("wrap_eol", 64'(out_eol[i]), 64'(i == 3 || i == 7));
            end
        end

        // Reset in the cycle after a read: that word is lost, next word is index 0.
        do_reset();
        push_word(24'hAAAAAA);
        push_word(24'hBBBBBB);
        last_pop = 1'b0;
        for (int i = 0; i < 20 && !last_pop; i++) step(1'b1);
        check("midrst_read_seen", 64'(last_pop), 64'(1));
        rst_n = 1'b0;
        step(1'b1); step(1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1);
        check("midrst_n", 64'(out_log.size()), 64'(1));
        if (out_log.size() == 1) begin
            check("midrst_word", 64'(out_log[0]), 64'(24'hBBBBBB));
            check("midrst_cnt", 64'(out_cnt[0]), 64'(0));
        end

`ifdef PIXEL_UNPACK_SWAP_EN
        do_reset();
        chan_swap = 1'b1;
        push_word(24'h112233);
        for (int i = 0; i < 5; i++) step(1'b1);
        chan_swap = 1'b0;
        push_word(24'h112233);
        for (int i = 0; i < 5; i++) step(1'b1);
        check("swap_n", 64'(out_log.size()), 64'(2));
        if (out_log.size() == 2) begin
            check("swap_on", 64'(out_log[0]), 64'(24'h332211));
            check("swap_off", 64'(out_log[1]), 64'(24'h112233));
        end
`endif

        // Random traffic and backpressure against the stream model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(3, 0) != 0);
            if ($urandom_range(2, 0) != 0 && src.size() < 8) push_word(24'($urandom));
        end
        for (int i = 0; i < 30; i++) step(1'b1);
        check("rand_drained", 64'(exp_q.size()), 64'(0));
        check("rand_some_out", 64'(out_log.size() > 100), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
